// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/DIV engine feeding the EX-stage HI/LO write path.
// Define EX_MULDIV_MADD_EN to turn op codes 100-111 into MADD/MADDU/MSUB/MSUBU accumulates.
module ex_muldiv #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              annul_i,
  output logic              busy_o,
  output logic              stall_req_o,
  output logic              done_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo, r_hi_o, r_lo_o;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_res, r_neg_rem;

  logic                w_abort, w_accept, w_is_div, w_signed, w_dz;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [DATA_W-1:0]   w_abs_a, w_abs_b, w_hi_nx, w_lo_nx, w_q, w_r;
  logic [DATA_W:0]     w_rsh, w_dif, w_sum;
  logic [2*DATA_W-1:0] w_prod, w_prod_s, w_mul_res, w_res;

  // A dropped start_i is treated exactly like an annul.
  assign w_abort  = annul_i | ~start_i;
  assign w_accept = (r_state == S_IDLE) & start_i & ~annul_i;
  assign w_is_div = (r_op[2:1] == 2'b01);
  assign w_signed = ~r_op[0];
  assign w_dz     = w_is_div & (r_b == '0);
  assign w_cnt_nx = r_cnt - CNT_W'(1);
  assign w_abs_a  = (w_signed & r_a[DATA_W-1]) ? -r_a : r_a;
  assign w_abs_b  = (w_signed & r_b[DATA_W-1]) ? -r_b : r_b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_PREP;
      S_PREP: begin
        if (w_abort)   w_state_nx = S_IDLE;
        else if (w_dz) w_state_nx = S_FIX;
        else           w_state_nx = S_RUN;
      end
      S_RUN: begin
        if (w_abort)              w_state_nx = S_IDLE;
        else if (w_cnt_nx == '0)  w_state_nx = S_FIX;
      end
      S_FIX:   w_state_nx = w_abort ? S_IDLE : S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // One RUN cycle: BITS_PER_CYCLE chained shift-add or restoring-subtract steps on {r_hi, r_lo}.
  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    w_rsh   = '0;
    w_dif   = '0;
    w_sum   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (w_is_div) begin
        w_rsh   = {w_hi_nx, w_lo_nx[DATA_W-1]};
        w_dif   = w_rsh - {1'b0, r_b};
        w_lo_nx = {w_lo_nx[DATA_W-2:0], ~w_dif[DATA_W]};
        w_hi_nx = w_dif[DATA_W] ? w_rsh[DATA_W-1:0] : w_dif[DATA_W-1:0];
      end else begin
        w_sum   = {1'b0, w_hi_nx} + (w_lo_nx[0] ? {1'b0, r_b} : '0);
        w_lo_nx = {w_sum[0], w_lo_nx[DATA_W-1:1]};
        w_hi_nx = w_sum[DATA_W:1];
      end
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_res ? -w_prod : w_prod;
  assign w_q      = r_neg_res ? -r_lo : r_lo;
  assign w_r      = r_neg_rem ? -r_hi : r_hi;

`ifdef EX_MULDIV_MADD_EN
  logic [DATA_W-1:0] r_hi_l, r_lo_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_l <= '0;
      r_lo_l <= '0;
    end else if (w_accept) begin
      r_hi_l <= hi_i;
      r_lo_l <= lo_i;
    end
  end

  always_comb begin
    w_mul_res = w_prod_s;
    if (r_op[2])
      w_mul_res = r_op[1] ? ({r_hi_l, r_lo_l} - w_prod_s) : ({r_hi_l, r_lo_l} + w_prod_s);
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = ^{hi_i, lo_i};
  assign w_mul_res    = w_prod_s;
`endif

  assign w_res = w_dz     ? {r_a, {DATA_W{1'b1}}} :
                 w_is_div ? {w_r, w_q} : w_mul_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi_o    <= '0;
      r_lo_o    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= op_i;
          r_a  <= opa_i;
          r_b  <= opb_i;
        end
        S_PREP: begin
          r_b       <= w_abs_b;
          r_lo      <= w_abs_a;
          r_hi      <= '0;
          r_cnt     <= CNT_W'(N);
          r_neg_res <= w_signed & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
          r_neg_rem <= w_signed & r_a[DATA_W-1];
        end
        S_RUN: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= w_cnt_nx;
        end
        default: ;
      endcase
      // Results only move on a completed op, so an annulled op leaves the old HI/LO visible.
      if (w_state_nx == S_DONE) begin
        r_hi_o <= w_res[2*DATA_W-1:DATA_W];
        r_lo_o <= w_res[DATA_W-1:0];
      end
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign whilo_o     = done_o;
  assign stall_req_o = start_i & ~done_o & ~annul_i & ~rst;
  assign hi_o        = r_hi_o;
  assign lo_o        = r_lo_o;

endmodule
